// File: rtl/address_sequencer_pkg.sv
// Shared definitions for the address sequencer: FSM state encoding
// and default dwell/timeout constants.
package address_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REQUEST    = 3'd1,
        S_WAIT_READY = 3'd2,
        S_DWELL      = 3'd3,
        S_ADVANCE    = 3'd4
    } state_t;

    localparam int DEFAULT_DWELL_TICKS    = 50;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // Counter width able to hold n itself
    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/address_sequencer_dwell_counter.sv
// Tick-enabled dwell counter; done flags the final tick of a word.
// clear has priority over tick.
module dwell_counter
    import address_sequencer_pkg::*;
#(
    parameter int DWELL_TICKS = DEFAULT_DWELL_TICKS
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int W = count_width(DWELL_TICKS);

    logic [W-1:0] count;

    // Count tick strobes since the last clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == W'(DWELL_TICKS - 1));

endmodule

// File: rtl/address_sequencer.sv
// Steps a read address through [START_ADDRESS..END_ADDRESS] with an
// unlock/ready handshake and a tick dwell per word. SEQ_TIMEOUT_EN adds a ready timeout.
module address_sequencer
    import address_sequencer_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 10,
    parameter int START_ADDRESS  = 0,
    parameter int END_ADDRESS    = 1023,
    parameter int DWELL_TICKS    = DEFAULT_DWELL_TICKS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     tick,
    input  logic                     ready,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     unlock,
    output logic                     busy,
    output logic                     wrap,
    output logic                     timeout
);

    localparam logic [ADDRESS_WIDTH-1:0] START_A = ADDRESS_WIDTH'(START_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] END_A   = ADDRESS_WIDTH'(END_ADDRESS);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] next_address;
    logic                     at_end;
    logic                     dwell_clear;
    logic                     dwell_tick;
    logic                     dwell_done;
    logic                     wait_expired;

    assign at_end       = (address == END_A);
    assign next_address = at_end ? START_A : address + 1'b1;
    assign dwell_clear  = (state == S_WAIT_READY) && ready;
    assign dwell_tick   = (state == S_DWELL) && tick;

    dwell_counter #(
        .DWELL_TICKS(DWELL_TICKS)
    ) u_dwell (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (dwell_clear),
        .tick   (dwell_tick),
        .done   (dwell_done)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = count_width(TIMEOUT_CYCLES);

    logic [TW-1:0] wait_count;
    logic          timeout_q;

    assign wait_expired = (wait_count == TW'(TIMEOUT_CYCLES - 1));
    assign timeout      = timeout_q;

    // Count cycles spent waiting for ready; flag is sticky until reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_count <= '0;
            timeout_q  <= 1'b0;
        end else if (state == S_REQUEST) begin
            wait_count <= '0;
        end else if (state == S_WAIT_READY && !ready) begin
            wait_count <= wait_count + 1'b1;
            if (wait_expired) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wait_expired       = 1'b0;
    assign timeout            = 1'b0;
`endif

    // Sequencer FSM with address register and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            address <= START_A;
            unlock  <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_REQUEST;
                        busy  <= 1'b1;
                    end
                end
                S_REQUEST: begin
                    unlock <= 1'b1;
                    state  <= S_WAIT_READY;
                end
                S_WAIT_READY: begin
                    if (ready) begin
                        unlock <= 1'b0;
                        state  <= S_DWELL;
                    end else if (wait_expired) begin
                        unlock  <= 1'b0;
                        address <= next_address;
                        wrap    <= at_end;
                        state   <= S_ADVANCE;
                    end
                end
                S_DWELL: begin
                    if (tick && dwell_done) begin
                        address <= next_address;
                        wrap    <= at_end;
                        state   <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (enable) begin
                        state <= S_REQUEST;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    unlock <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Randomized word-level bench for address_sequencer.
// Timeout checks are compiled only when SEQ_TIMEOUT_EN is defined.
module tb_address_sequencer;

    localparam int AW    = 3;
    localparam int START = 2;
    localparam int END   = 7;
    localparam int DWELL = 3;
    localparam int TMO   = 16;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable  = 1'b0;
    logic          tick    = 1'b0;
    logic          ready   = 1'b0;
    logic [AW-1:0] address;
    logic          unlock;
    logic          busy;
    logic          wrap;
    logic          timeout;

    int      n_checks = 0;
    int      n_errors = 0;
    int      exp_addr;
    bit      exp_tmo;

    address_sequencer #(
        .ADDRESS_WIDTH (AW),
        .START_ADDRESS (START),
        .END_ADDRESS   (END),
        .DWELL_TICKS   (DWELL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (enable),
        .tick   (tick),
        .ready  (ready),
        .address(address),
        .unlock (unlock),
        .busy   (busy),
        .wrap   (wrap),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Word order: START..END then back to START
    function automatic int model_next(input int a);
        if (a == END) return START;
        return (a + 1) % (1 << AW);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // From idle: enable, expect unlock exactly two edges later
    task automatic start_run();
        enable = 1'b1;
        cyc();
        check("req_unlock", 32'(unlock), 0);
        check("req_busy", 32'(busy), 1);
        cyc();
        check("lat_unlock", 32'(unlock), 1);
    endtask

    // Entered with unlock just asserted for exp_addr
    task automatic word(input int delay, input bit drop);
        check("wr_addr", 32'(address), 32'(exp_addr));
        check("wr_busy", 32'(busy), 1);
        check("wr_tmo", 32'(timeout), 32'(exp_tmo));
        for (int i = 0; i < delay; i++) begin
            ready = 1'b0;
            tick  = 1'($urandom);
            cyc();
            check("wait_unlock", 32'(unlock), 1);
            check("wait_addr", 32'(address), 32'(exp_addr));
        end
        ready = 1'b1;
        tick  = 1'($urandom);
        cyc();
        check("ack_unlock", 32'(unlock), 0);
        check("ack_addr", 32'(address), 32'(exp_addr));
        for (int k = 0; k < DWELL; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick  = 1'b0;
                ready = 1'($urandom);
                cyc();
                check("dwell_addr", 32'(address), 32'(exp_addr));
                check("dwell_unlock", 32'(unlock), 0);
            end
            if (drop) enable = 1'b0;
            tick  = 1'b1;
            ready = 1'($urandom);
            cyc();
            if (k < DWELL - 1)
                check("dwell_hold", 32'(address), 32'(exp_addr));
        end
        tick  = 1'b0;
        ready = 1'b0;
        check("adv_wrap", 32'(wrap), 32'(exp_addr == END));
        check("adv_addr", 32'(address), 32'(model_next(exp_addr)));
        check("adv_busy", 32'(busy), 1);
        exp_addr = model_next(exp_addr);
        cyc();
        check("wrap_pulse", 32'(wrap), 0);
        if (drop) begin
            check("idle_busy", 32'(busy), 0);
            check("idle_unlock", 32'(unlock), 0);
            for (int i = 0; i < 3; i++) begin
                tick  = 1'($urandom);
                ready = 1'($urandom);
                cyc();
                check("idle_hold_busy", 32'(busy), 0);
                check("idle_hold_addr", 32'(address), 32'(exp_addr));
            end
            tick  = 1'b0;
            ready = 1'b0;
            start_run();
        end else begin
            check("re_unlock", 32'(unlock), 0);
            check("re_busy", 32'(busy), 1);
            cyc();
            check("re_req", 32'(unlock), 1);
        end
    endtask

    // Reset while waiting for ready, then restart from START
    task automatic reset_mid();
        ready = 1'b0;
        cyc();
        check("mid_unlock", 32'(unlock), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_unlock", 32'(unlock), 0);
        check("mid_rst_addr", 32'(address), START);
        check("mid_rst_busy", 32'(busy), 0);
        exp_addr = START;
        exp_tmo  = 1'b0;
        cyc();
        reset_n = 1'b1;
        start_run();
    endtask

`ifdef SEQ_TIMEOUT_EN
    // Never answer ready: word is skipped after TMO cycles
    task automatic timeout_word();
        ready = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick = 1'($urandom);
            cyc();
            check("tmo_unlock_hi", 32'(unlock), 1);
        end
        tick = 1'b0;
        cyc();
        check("tmo_unlock_lo", 32'(unlock), 0);
        check("tmo_flag", 32'(timeout), 1);
        check("tmo_addr", 32'(address), 32'(model_next(exp_addr)));
        check("tmo_wrap", 32'(wrap), 32'(exp_addr == END));
        exp_addr = model_next(exp_addr);
        exp_tmo  = 1'b1;
        cyc();
        check("tmo_req_unlock", 32'(unlock), 0);
        check("tmo_sticky", 32'(timeout), 1);
        cyc();
        check("tmo_re_req", 32'(unlock), 1);
    endtask
`endif

    initial begin
        exp_addr = START;
        exp_tmo  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_addr", 32'(address), START);
        check("rst_unlock", 32'(unlock), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_tmo", 32'(timeout), 0);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        check("idle_no_enable", 32'(busy), 0);
        start_run();
        for (int w = 0; w < 18; w++) begin
            int  delay;
            bit  drop;
            if (w == 6) reset_mid();
`ifdef SEQ_TIMEOUT_EN
            if (w == 10) timeout_word();
`endif
            delay = (w == 3) ? 20 : $urandom_range(0, 4);
            drop  = (w == 4) || ($urandom_range(0, 5) == 0);
            word(delay, drop);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
